// File: rtl/riscv_v_exe_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : riscv_v_exe_wb_buffer
// Brief    : In-order writeback FIFO draining vector ALU results to the VRF,
//            v0 mask and IRF write ports, with a pending-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_v_exe_wb_buffer #(
    parameter int DEPTH    = 4,
    parameter int VLEN     = 128,
    parameter int NUM_ELEM = 16,
    parameter int XLEN     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                exe_valid,
    output logic                exe_ready,
    input  logic [VLEN-1:0]     exe_vec_result,
    input  logic [VLEN/8-1:0]   exe_vec_be,
    input  logic [4:0]          exe_vdst,
    input  logic                exe_wr_vec,
    input  logic [NUM_ELEM-1:0] exe_mask_result,
    input  logic                exe_wr_mask,
    input  logic [XLEN-1:0]     exe_int_result,
    input  logic [4:0]          exe_rdst,
    input  logic                exe_wr_int,
    output logic                vrf_we,
    output logic [4:0]          vrf_waddr,
    output logic [VLEN-1:0]     vrf_wdata,
    output logic [VLEN/8-1:0]   vrf_wbe,
    input  logic                vrf_ready,
    output logic                mask_we,
    output logic [NUM_ELEM-1:0] mask_wdata,
    input  logic                mask_ready,
    output logic                irf_we,
    output logic [4:0]          irf_waddr,
    output logic [XLEN-1:0]     irf_wdata,
    input  logic                irf_ready,
    output logic [31:0]         busy_vreg,
    output logic                busy_v0,
    output logic [31:0]         busy_xreg
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]  C_DEPTH = (PTR_W+1)'(DEPTH);

    logic [VLEN-1:0]     r_vec_data  [DEPTH];
    logic [VLEN/8-1:0]   r_vec_be    [DEPTH];
    logic [4:0]          r_vdst      [DEPTH];
    logic [NUM_ELEM-1:0] r_mask_data [DEPTH];
    logic [XLEN-1:0]     r_int_data  [DEPTH];
    logic [4:0]          r_rdst      [DEPTH];

    logic [DEPTH-1:0] r_pend_vec, r_pend_mask, r_pend_int;
    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_head_valid, w_push, w_pop;
    logic             w_vrf_fire, w_mask_fire, w_irf_fire;
    logic [DEPTH-1:0] w_valid;
    logic [31:0]      w_busy_vreg, w_busy_xreg;
    logic             w_busy_v0;

    assign w_head_valid = (r_count != '0);
    assign exe_ready    = (r_count != C_DEPTH);
    assign w_push       = exe_valid & exe_ready;

    // Write requests are gated only by reset-cleared state, never by data.
    assign vrf_we     = w_head_valid & r_pend_vec[r_rd_ptr];
    assign vrf_waddr  = r_vdst[r_rd_ptr];
    assign vrf_wdata  = r_vec_data[r_rd_ptr];
    assign vrf_wbe    = r_vec_be[r_rd_ptr];
    assign mask_we    = w_head_valid & r_pend_mask[r_rd_ptr];
    assign mask_wdata = r_mask_data[r_rd_ptr];
    assign irf_we     = w_head_valid & r_pend_int[r_rd_ptr];
    assign irf_waddr  = r_rdst[r_rd_ptr];
    assign irf_wdata  = r_int_data[r_rd_ptr];

    assign w_vrf_fire  = vrf_we  & vrf_ready;
    assign w_mask_fire = mask_we & mask_ready;
    assign w_irf_fire  = irf_we  & irf_ready;

    assign w_pop = w_head_valid
                 & (w_vrf_fire  | ~r_pend_vec[r_rd_ptr])
                 & (w_mask_fire | ~r_pend_mask[r_rd_ptr])
                 & (w_irf_fire  | ~r_pend_int[r_rd_ptr]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_vec  <= '0;
            r_pend_mask <= '0;
            r_pend_int  <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
        end else if (flush) begin
            r_pend_vec  <= '0;
            r_pend_mask <= '0;
            r_pend_int  <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
        end else begin
            if (w_vrf_fire)  r_pend_vec[r_rd_ptr]  <= 1'b0;
            if (w_mask_fire) r_pend_mask[r_rd_ptr] <= 1'b0;
            if (w_irf_fire)  r_pend_int[r_rd_ptr]  <= 1'b0;
            if (w_push) begin
                r_pend_vec[r_wr_ptr]  <= exe_wr_vec;
                r_pend_mask[r_wr_ptr] <= exe_wr_mask;
                r_pend_int[r_wr_ptr]  <= exe_wr_int & (exe_rdst != 5'd0);
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_vec_data[r_wr_ptr]  <= exe_vec_result;
            r_vec_be[r_wr_ptr]    <= exe_vec_be;
            r_vdst[r_wr_ptr]      <= exe_vdst;
            r_mask_data[r_wr_ptr] <= exe_mask_result;
            r_int_data[r_wr_ptr]  <= exe_int_result;
            r_rdst[r_wr_ptr]      <= exe_rdst;
        end
    end

    // Entry i is live when its distance from the head is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        logic [PTR_W-1:0] w_off;
        assign w_off       = PTR_W'(gi) - r_rd_ptr;
        assign w_valid[gi] = ({1'b0, w_off} < r_count);
    end

    always_comb begin
        w_busy_vreg = '0;
        w_busy_xreg = '0;
        w_busy_v0   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && r_pend_vec[i])  w_busy_vreg[r_vdst[i]] = 1'b1;
            if (w_valid[i] && r_pend_int[i])  w_busy_xreg[r_rdst[i]] = 1'b1;
            if (w_valid[i] && r_pend_mask[i]) w_busy_v0 = 1'b1;
        end
    end

    assign busy_vreg = w_busy_vreg;
    assign busy_v0   = w_busy_v0;
    assign busy_xreg = {w_busy_xreg[31:1], 1'b0};

endmodule
`default_nettype wire

// File: tb/tb_riscv_v_exe_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_v_exe_wb_buffer
// Brief    : Randomized bench for riscv_v_exe_wb_buffer against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_v_exe_wb_buffer;

    localparam int DEPTH    = 4;
    localparam int VLEN     = 128;
    localparam int NUM_ELEM = 16;
    localparam int XLEN     = 32;

    logic                clk = 1'b0;
    logic                rst, flush, exe_valid, exe_ready;
    logic [VLEN-1:0]     exe_vec_result;
    logic [VLEN/8-1:0]   exe_vec_be;
    logic [4:0]          exe_vdst, exe_rdst;
    logic                exe_wr_vec, exe_wr_mask, exe_wr_int;
    logic [NUM_ELEM-1:0] exe_mask_result;
    logic [XLEN-1:0]     exe_int_result;
    logic                vrf_we, vrf_ready, mask_we, mask_ready, irf_we, irf_ready;
    logic [4:0]          vrf_waddr, irf_waddr;
    logic [VLEN-1:0]     vrf_wdata;
    logic [VLEN/8-1:0]   vrf_wbe;
    logic [NUM_ELEM-1:0] mask_wdata;
    logic [XLEN-1:0]     irf_wdata;
    logic [31:0]         busy_vreg, busy_xreg;
    logic                busy_v0;

    riscv_v_exe_wb_buffer #(
        .DEPTH(DEPTH), .VLEN(VLEN), .NUM_ELEM(NUM_ELEM), .XLEN(XLEN)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .exe_valid(exe_valid), .exe_ready(exe_ready),
        .exe_vec_result(exe_vec_result), .exe_vec_be(exe_vec_be),
        .exe_vdst(exe_vdst), .exe_wr_vec(exe_wr_vec),
        .exe_mask_result(exe_mask_result), .exe_wr_mask(exe_wr_mask),
        .exe_int_result(exe_int_result), .exe_rdst(exe_rdst), .exe_wr_int(exe_wr_int),
        .vrf_we(vrf_we), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata),
        .vrf_wbe(vrf_wbe), .vrf_ready(vrf_ready),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .mask_ready(mask_ready),
        .irf_we(irf_we), .irf_waddr(irf_waddr), .irf_wdata(irf_wdata),
        .irf_ready(irf_ready),
        .busy_vreg(busy_vreg), .busy_v0(busy_v0), .busy_xreg(busy_xreg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VLEN-1:0]     vec;
        logic [VLEN/8-1:0]   be;
        logic [4:0]          vdst;
        logic [NUM_ELEM-1:0] mask;
        logic [XLEN-1:0]     ival;
        logic [4:0]          rdst;
        bit                  pv, pm, pi;
    } ent_t;

    ent_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, exe_ready, 1'b1);
        check({tag, "_we"}, {vrf_we, mask_we, irf_we}, 3'b000);
        check({tag, "_busy_vreg"}, busy_vreg, 32'd0);
        check({tag, "_busy_v0"}, busy_v0, 1'b0);
        check({tag, "_busy_xreg"}, busy_xreg, 32'd0);
    endtask

    initial begin
        int   prob;
        bit   hv, e_vwe, e_mwe, e_iwe, acc;
        logic [31:0] e_bv, e_bx;
        bit   e_b0;
        ent_t h, n;

        rst = 1'b1; flush = 1'b0; exe_valid = 1'b0;
        exe_vec_result = '0; exe_vec_be = '0; exe_vdst = '0; exe_wr_vec = 1'b0;
        exe_mask_result = '0; exe_wr_mask = 1'b0; exe_int_result = '0;
        exe_rdst = '0; exe_wr_int = 1'b0;
        vrf_ready = 1'b0; mask_ready = 1'b0; irf_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check_idle("reset");

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst = 1'b0;
            case ((cyc / 200) % 4)
                0:       prob = 100;
                1:       prob = 50;
                2:       prob = 20;
                default: prob = 75;
            endcase
            vrf_ready  = ($urandom_range(1, 100) <= prob);
            mask_ready = ($urandom_range(1, 100) <= prob);
            irf_ready  = ($urandom_range(1, 100) <= prob);
            flush      = ($urandom_range(0, 49) == 0);
            exe_valid  = ($urandom_range(0, 3) != 0);
            exe_vec_result  = {$urandom, $urandom, $urandom, $urandom};
            exe_vec_be      = 16'($urandom);
            exe_vdst        = 5'($urandom);
            exe_wr_vec      = 1'($urandom);
            exe_mask_result = 16'($urandom);
            exe_wr_mask     = 1'($urandom);
            exe_int_result  = $urandom;
            exe_rdst        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            exe_wr_int      = 1'($urandom);
            #1;

            if (cyc == 777 || cyc == 2100) begin
                rst = 1'b1;
                #1 check_idle("async_rst");
                q.delete();
                @(posedge clk);
                continue;
            end

            hv    = (q.size() > 0);
            e_vwe = hv && q[0].pv;
            e_mwe = hv && q[0].pm;
            e_iwe = hv && q[0].pi;
            acc   = (q.size() < DEPTH);
            e_bv = '0; e_bx = '0; e_b0 = 1'b0;
            foreach (q[k]) begin
                if (q[k].pv) e_bv[q[k].vdst] = 1'b1;
                if (q[k].pi) e_bx[q[k].rdst] = 1'b1;
                if (q[k].pm) e_b0 = 1'b1;
            end

            check("exe_ready", exe_ready, acc);
            check("vrf_we", vrf_we, e_vwe);
            check("mask_we", mask_we, e_mwe);
            check("irf_we", irf_we, e_iwe);
            check("busy_vreg", busy_vreg, e_bv);
            check("busy_v0", busy_v0, e_b0);
            check("busy_xreg", busy_xreg, e_bx);
            if (e_vwe) begin
                check("vrf_waddr", vrf_waddr, q[0].vdst);
                check("vrf_wdata", vrf_wdata, q[0].vec);
                check("vrf_wbe", vrf_wbe, q[0].be);
            end
            if (e_mwe) check("mask_wdata", mask_wdata, q[0].mask);
            if (e_iwe) begin
                check("irf_waddr", irf_waddr, q[0].rdst);
                check("irf_wdata", irf_wdata, q[0].ival);
            end

            // Model the edge: fired ports complete, fully-written head retires.
            if (hv) begin
                h = q[0];
                if (vrf_ready)  h.pv = 1'b0;
                if (mask_ready) h.pm = 1'b0;
                if (irf_ready)  h.pi = 1'b0;
                q[0] = h;
                if (!h.pv && !h.pm && !h.pi) void'(q.pop_front());
            end
            if (flush) begin
                q.delete();
            end else if (exe_valid && acc) begin
                n.vec  = exe_vec_result;  n.be   = exe_vec_be;   n.vdst = exe_vdst;
                n.mask = exe_mask_result; n.ival = exe_int_result; n.rdst = exe_rdst;
                n.pv   = exe_wr_vec;
                n.pm   = exe_wr_mask;
                n.pi   = exe_wr_int && (exe_rdst != 5'd0);
                q.push_back(n);
            end
            @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_v_exe_wb_buffer.md
# riscv_v_exe_wb_buffer

In-order writeback buffer at the consuming end of the vector execute ALU result interface. It accepts one result bundle per cycle from the execute stage: a vector result, a mask result, an integer result and their destinations. It holds the bundles in a small FIFO and drains them in order to the vector register file (VRF) write port, the v0 mask write port and the integer register file (IRF) write port. It supports independent per-port backpressure and publishes a pending-write scoreboard for hazard detection.

## Interface
- DEPTH, 4, number of buffered result bundles; power of two, ≥2
- VLEN, 128, vector result width in bits
- NUM_ELEM, 16, mask result width in bits
- XLEN, 32, integer result width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous: discard all buffered entries
- exe_valid  in  1  result bundle valid
- exe_ready  out  1  buffer can accept a bundle
- exe_vec_result  in  VLEN  vector result
- exe_vec_be  in  VLEN/8  vector byte enables
- exe_vdst  in  5  destination vector register
- exe_wr_vec  in  1  bundle writes the VRF
- exe_mask_result  in  NUM_ELEM  mask result
- exe_wr_mask  in  1  bundle writes v0
- exe_int_result  in  XLEN  integer result
- exe_rdst  in  5  destination integer register
- exe_wr_int  in  1  bundle writes the IRF; ignored when exe_rdst==0
- vrf_we / vrf_waddr / vrf_wdata / vrf_wbe  out  1/5/VLEN/VLEN/8  VRF write request
- vrf_ready  in  1  VRF accepts the write this cycle
- mask_we / mask_wdata  out  1/NUM_ELEM  v0 write request
- mask_ready  in  1  v0 port accepts the write
- irf_we / irf_waddr / irf_wdata  out  1/5/XLEN  IRF write request
- irf_ready  in  1  IRF accepts the write
- busy_vreg  out  32  bit i set: pending VRF write to vi
- busy_v0  out  1  pending mask write
- busy_xreg  out  32  bit i set: pending IRF write to xi; bit 0 is always 0

## Operation
- Storage: DEPTH entries, each holding the captured data plus three pending bits (pend_vec, pend_mask, pend_int). Read and write pointers use log2(DEPTH) bits and wrap modulo DEPTH. The count register is log2(DEPTH)+1 bits.
- Push: exe_valid && exe_ready writes the entry at wr_ptr. Pending bits are set to {exe_wr_vec, exe_wr_mask, exe_wr_int && exe_rdst!=0}.
- exe_ready = (count != DEPTH). It does not depend on pops in the same cycle, so there is no pass-through when full.
- Head drive: the write requests are combinational from the head entry. vrf_we = valid && pend_vec; mask_we = valid && pend_mask; irf_we = valid && pend_int.
- A port fires when it has both we and ready. A fired port clears its pending bit at the edge. The other ports keep requesting until they fire.
- Pop: the head retires at the edge when every pending bit is set in its port's fire signal this cycle. An entry with no pending bits retires in its first cycle at the head.
- Ordering: writes on each port leave in push order. A later entry never writes before the head retires.
- Scoreboard: busy_* is the OR over valid entries of one-hot(dst) gated by the matching pending bit. It is computed combinationally from the registered state.
- Flush: clears count, both pointers and all pending bits at the edge. Flush has priority over a push and a pop in the same cycle. Port writes firing in the flush cycle still complete at the port.

## Timing
- Reset state: count=0, pointers=0, all pending bits=0. Resulting outputs: exe_ready=1, vrf_we=mask_we=irf_we=0, busy_vreg=0, busy_v0=0, busy_xreg=0. Data outputs are don't-care but must not be X-gated into the we signals.
- Latency: a bundle pushed at edge N can be written to its ports in cycle N+1 at the earliest.
- busy bits rise in the cycle after the push. They fall in the cycle after the corresponding port fires.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Pending writes are lost.
- Throughput: one bundle per cycle when all readies are high.

## Test plan
- Single push {wr_vec=1, vdst=3, data=0xA5..}, all readies high -> vrf_we=1 with waddr=3 one cycle later; busy_vreg[3] high for exactly one cycle; exe_ready stays 1.
- Fill: push 4 bundles with all readies low -> exe_ready=0 after the 4th push. A 5th exe_valid is not accepted. Raising vrf_ready drains the 4 writes in push order.
- Split backpressure: bundle {wr_vec, wr_int, rdst=5}, vrf_ready=1, irf_ready=0 for 3 cycles -> vrf_we pulses once; irf_we held for 4 cycles; the entry retires when irf_ready rises; busy_xreg[5] clears the next cycle.
- exe_rdst=0 with wr_int=1 and no other writes -> irf_we never asserts; the entry retires in 1 cycle.
- Flush with 3 entries buffered and a push in the same cycle -> count=0 and all busy bits=0 next cycle; the pushed bundle is dropped.
- Assert rst asynchronously mid-drain -> all we and busy outputs drop to 0 before the next edge; exe_ready=1.
